// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue/status bundle between the pipeline and the HI/LO multiply/divide sequencer.
interface muldiv_seq_if;
    logic       start;
    logic [1:0] op;
    logic       flush;
    logic       d_hilo;
    logic       busy;
    logic       stall_md;
    logic [1:0] op_q;
    logic       load;
    logic       hilo_we;
    logic       err_start;
    modport master (output start, op, flush, d_hilo,
                    input  busy, stall_md, op_q, load, hilo_we, err_start);
    modport slave  (input  start, op, flush, d_hilo,
                    output busy, stall_md, op_q, load, hilo_we, err_start);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: counts MULT/DIV latency, strobes operand load and HI/LO write-back, raises the HI/LO hazard stall.
module muldiv_seq #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus
);
    localparam logic [0:0]       IDLE   = 1'b0;
    localparam logic [0:0]       RUN    = 1'b1;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_lat_q, op_lat_d;
    logic             load_q, load_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_lat_d = op_lat_q;
        load_d   = 1'b0;
        we_d     = 1'b0;
        err_d    = err_q | (bus.start & (state_q == RUN));
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                state_d  = RUN;
                op_lat_d = bus.op;
                cnt_d    = bus.op[1] ? DIV_LD : MUL_LD;
                load_d   = 1'b1;
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
            we_d    = 1'b1;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_lat_q <= 2'b00;
            load_q   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_lat_q <= op_lat_d;
            load_q   <= load_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end
    // An op waiting in E (start, not flushed) already blocks the D-stage HI/LO user.
    assign bus.stall_md  = bus.d_hilo & ((state_q == RUN) | (bus.start & ~bus.flush));
    assign bus.busy      = (state_q == RUN);
    assign bus.op_q      = op_lat_q;
    assign bus.load      = load_q;
    assign bus.hilo_we   = we_q;
    assign bus.err_start = err_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven cycle vectors for muldiv_seq plus a hand-written async-reset sequence.
module tb_muldiv_seq;
    typedef struct {
        int         n;
        logic       start;
        logic [1:0] op;
        logic       flush;
        logic       d_hilo;
        logic       busy;
        logic       stall;
        logic       load;
        logic       we;
        logic       err;
        logic [1:0] opq;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];

    muldiv_seq_if bus();
    muldiv_seq #(.MUL_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int n, logic st, logic [1:0] op, logic fl, logic dh,
                                logic b, logic s, logic l, logic w, logic e, logic [1:0] oq);
        vec_t v;
        v.n = n; v.start = st; v.op = op; v.flush = fl; v.d_hilo = dh;
        v.busy = b; v.stall = s; v.load = l; v.we = w; v.err = e; v.opq = oq;
        return v;
    endfunction

    task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic st, logic [1:0] op, logic fl, logic dh);
        @(posedge clk);
        #1;
        bus.start = st; bus.op = op; bus.flush = fl; bus.d_hilo = dh;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.flush = 1'b0; bus.d_hilo = 1'b0;
        // idle
        tbl.push_back(mk(2, 0,0,0,0, 0,0,0,0,0,0));
        // MULT
        tbl.push_back(mk(1, 1,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(4, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,1,0,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,0));
        // DIVU with MFLO held in D
        tbl.push_back(mk(1, 1,3,0,1, 0,1,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0,1, 1,1,1,0,0,3));
        tbl.push_back(mk(9, 0,0,0,1, 1,1,0,0,0,3));
        tbl.push_back(mk(1, 0,0,0,1, 0,0,0,1,0,3));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,3));
        // MULTU then DIV issued in the hilo_we cycle
        tbl.push_back(mk(1, 1,1,0,0, 0,0,0,0,0,3));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,1,0,0,1));
        tbl.push_back(mk(4, 0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1, 1,2,0,0, 0,0,0,1,0,1));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,1,0,0,2));
        tbl.push_back(mk(9, 0,0,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,1,0,2));
        // DIV flushed in cycle 4
        tbl.push_back(mk(1, 1,2,0,0, 0,0,0,0,0,2));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,1,0,0,2));
        tbl.push_back(mk(2, 0,0,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(1, 0,0,1,0, 1,0,0,0,0,2));
        tbl.push_back(mk(12,0,0,0,0, 0,0,0,0,0,2));
        // flush together with start
        tbl.push_back(mk(1, 1,1,1,1, 0,0,0,0,0,2));
        tbl.push_back(mk(2, 0,0,0,0, 0,0,0,0,0,2));
        // start during a MULT
        tbl.push_back(mk(1, 1,0,0,0, 0,0,0,0,0,2));
        tbl.push_back(mk(1, 0,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(1, 1,3,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(3, 0,0,0,0, 1,0,0,0,1,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,1,1,0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0,1,0));

        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", {1'b0, bus.busy}, 2'd0);
        chk("rst_load", {1'b0, bus.load}, 2'd0);
        chk("rst_we",   {1'b0, bus.hilo_we}, 2'd0);
        chk("rst_err",  {1'b0, bus.err_start}, 2'd0);
        chk("rst_opq",  bus.op_q, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(tbl[i].start, tbl[i].op, tbl[i].flush, tbl[i].d_hilo);
                @(negedge clk);
                chk($sformatf("row%0d.%0d busy", i, k),  {1'b0, bus.busy},      {1'b0, tbl[i].busy});
                chk($sformatf("row%0d.%0d stall", i, k), {1'b0, bus.stall_md},  {1'b0, tbl[i].stall});
                chk($sformatf("row%0d.%0d load", i, k),  {1'b0, bus.load},      {1'b0, tbl[i].load});
                chk($sformatf("row%0d.%0d we", i, k),    {1'b0, bus.hilo_we},   {1'b0, tbl[i].we});
                chk($sformatf("row%0d.%0d err", i, k),   {1'b0, bus.err_start}, {1'b0, tbl[i].err});
                chk($sformatf("row%0d.%0d opq", i, k),   bus.op_q,              tbl[i].opq);
            end
        end

        // DIV, async reset asserted between edges in cycle 7 (cnt=3)
        drive(1'b1, 2'b10, 1'b0, 1'b0);
        repeat (7) drive(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_busy", {1'b0, bus.busy}, 2'd1);
        chk("pre_rst_opq",  bus.op_q, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {1'b0, bus.busy}, 2'd0);
        chk("arst_load", {1'b0, bus.load}, 2'd0);
        chk("arst_we",   {1'b0, bus.hilo_we}, 2'd0);
        chk("arst_err",  {1'b0, bus.err_start}, 2'd0);
        chk("arst_opq",  bus.op_q, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d busy", k), {1'b0, bus.busy}, 2'd0);
            chk($sformatf("post_rst%0d we", k),   {1'b0, bus.hilo_we}, 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
